// File: rtl/dmem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_port_arbiter_if
// Description : Request/response bundle for one data-memory requester port.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              req;
    logic              rw;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (
        output req, rw, size, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, rw, size, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface
`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_port_arbiter
// Description : Round-robin two-port arbiter and one-cycle access sequencer for
//               the 256-byte big-endian data memory. Optional alignment check
//               enabled by defining DMEM_ALIGN_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_port_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    dmem_port_arbiter_if.slave p0,
    dmem_port_arbiter_if.slave p1,
    output logic [ADDR_W-1:0]  mem_A,
    output logic [DATA_W-1:0]  mem_DI,
    output logic [1:0]         mem_Size,
    output logic               mem_RW,
    output logic               mem_E,
    input  logic [DATA_W-1:0]  mem_DO,
    output logic               busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t            state_q,   state_d;
    logic              rr_ptr_q,  rr_ptr_d;
    logic              port_q,    port_d;
    logic              rej_q,     rej_d;
    logic [ADDR_W-1:0] mem_a_q,   mem_a_d;
    logic [DATA_W-1:0] mem_di_q,  mem_di_d;
    logic [1:0]        mem_size_q, mem_size_d;
    logic              mem_rw_q,  mem_rw_d;
    logic              mem_e_q,   mem_e_d;
    logic [DATA_W-1:0] rdata0_q,  rdata0_d;
    logic [DATA_W-1:0] rdata1_q,  rdata1_d;
    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;
    logic              err0_q,    err0_d;
    logic              err1_q,    err1_d;

    logic              w_idle;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_req_rw;
    logic [1:0]        w_req_size;
    logic [ADDR_W-1:0] w_req_addr;
    logic [DATA_W-1:0] w_req_wdata;
    logic              w_reject;
    logic [DATA_W-1:0] w_resp_data;

    assign w_idle = (state_q == S_IDLE);

    // On contention the port named by rr_ptr wins; a lone requester always wins.
    assign w_gnt0 = w_idle && !rst && p0.req && (!p1.req || !rr_ptr_q);
    assign w_gnt1 = w_idle && !rst && p1.req && (!p0.req ||  rr_ptr_q);

    assign w_req_rw    = w_gnt1 ? p1.rw    : p0.rw;
    assign w_req_size  = w_gnt1 ? p1.size  : p0.size;
    assign w_req_addr  = w_gnt1 ? p1.addr  : p0.addr;
    assign w_req_wdata = w_gnt1 ? p1.wdata : p0.wdata;

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_reject = (w_req_size == 2'b11)
                   || ((w_req_size == 2'b01) && w_req_addr[0])
                   || ((w_req_size == 2'b10) && (w_req_addr[1:0] != 2'b00));
`else
    assign w_reject = (w_req_size == 2'b11);
`endif

    // Memory returns right-justified data; mask so narrow reads are zero-extended.
    always_comb begin
        w_resp_data = '0;
        if (!mem_rw_q && !rej_q) begin
            case (mem_size_q)
                2'b00:   w_resp_data = DATA_W'(mem_DO[7:0]);
                2'b01:   w_resp_data = DATA_W'(mem_DO[15:0]);
                default: w_resp_data = mem_DO;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        port_d     = port_q;
        rej_d      = rej_q;
        mem_a_d    = mem_a_q;
        mem_di_d   = mem_di_q;
        mem_size_d = mem_size_q;
        mem_rw_d   = 1'b0;
        mem_e_d    = 1'b0;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        rvalid0_d  = 1'b0;
        rvalid1_d  = 1'b0;
        err0_d     = err0_q;
        err1_d     = err1_q;

        case (state_q)
            S_IDLE: begin
                if (w_gnt0 || w_gnt1) begin
                    state_d  = S_ACCESS;
                    rr_ptr_d = ~w_gnt1;
                    port_d   = w_gnt1;
                    rej_d    = w_reject;
                    // Rejected requests spend the access slot without touching memory.
                    if (!w_reject) begin
                        mem_a_d    = w_req_addr;
                        mem_di_d   = w_req_wdata;
                        mem_size_d = w_req_size;
                        mem_rw_d   = w_req_rw;
                        mem_e_d    = w_req_rw;
                    end
                end
            end
            S_ACCESS: begin
                state_d = S_RESP;
                if (port_q) begin
                    rvalid1_d = 1'b1;
                    rdata1_d  = w_resp_data;
                    err1_d    = rej_q;
                end else begin
                    rvalid0_d = 1'b1;
                    rdata0_d  = w_resp_data;
                    err0_d    = rej_q;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= 1'b0;
            port_q     <= 1'b0;
            rej_q      <= 1'b0;
            mem_a_q    <= '0;
            mem_di_q   <= '0;
            mem_size_q <= 2'b00;
            mem_rw_q   <= 1'b0;
            mem_e_q    <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            err0_q     <= 1'b0;
            err1_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            port_q     <= port_d;
            rej_q      <= rej_d;
            mem_a_q    <= mem_a_d;
            mem_di_q   <= mem_di_d;
            mem_size_q <= mem_size_d;
            mem_rw_q   <= mem_rw_d;
            mem_e_q    <= mem_e_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            err0_q     <= err0_d;
            err1_q     <= err1_d;
        end
    end

    assign mem_A     = mem_a_q;
    assign mem_DI    = mem_di_q;
    assign mem_Size  = mem_size_q;
    assign mem_RW    = mem_rw_q;
    assign mem_E     = mem_e_q;
    assign busy      = !w_idle;

    assign p0.gnt    = w_gnt0;
    assign p0.rvalid = rvalid0_q;
    assign p0.rdata  = rdata0_q;
    assign p0.err    = err0_q;
    assign p1.gnt    = w_gnt1;
    assign p1.rvalid = rvalid1_q;
    assign p1.rdata  = rdata1_q;
    assign p1.err    = err1_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_port_arbiter
// Description : Directed plus random traffic on both ports against a byte-array
//               reference model; honours DMEM_ALIGN_CHECK_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_port_arbiter;
    localparam int AW = 8;
    localparam int DW = 32;

    logic clk  = 1'b0;
    logic rst  = 1'b0;
    logic fill = 1'b1;
    always #5 clk = ~clk;

    dmem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) p0_if ();
    dmem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) p1_if ();

    logic [AW-1:0] mem_A;
    logic [DW-1:0] mem_DI;
    logic [DW-1:0] mem_DO;
    logic [1:0]    mem_Size;
    logic          mem_RW;
    logic          mem_E;
    logic          busy;

    dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .p0(p0_if), .p1(p1_if),
        .mem_A(mem_A), .mem_DI(mem_DI), .mem_Size(mem_Size), .mem_RW(mem_RW),
        .mem_E(mem_E), .mem_DO(mem_DO), .busy(busy)
    );

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 29) ^ 90);
    endfunction

    function automatic logic [31:0] be_val(input logic [1:0] size, input logic [7:0] b0,
                                           input logic [7:0] b1, input logic [7:0] b2,
                                           input logic [7:0] b3);
        case (size)
            2'd0:    return {24'd0, b0};
            2'd1:    return {16'd0, b0, b1};
            2'd2:    return {b0, b1, b2, b3};
            default: return 32'd0;
        endcase
    endfunction

    // Memory attached to the DUT: combinational big-endian read, write at cycle end.
    logic [7:0] env_mem [256];
    always_comb mem_DO = be_val(mem_Size, env_mem[mem_A], env_mem[mem_A + 8'd1],
                                env_mem[mem_A + 8'd2], env_mem[mem_A + 8'd3]);
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 256; i++) env_mem[i] <= pat(i);
        end else if (mem_E) begin
            case (mem_Size)
                2'd0: env_mem[mem_A] <= mem_DI[7:0];
                2'd1: begin
                    env_mem[mem_A]        <= mem_DI[15:8];
                    env_mem[mem_A + 8'd1] <= mem_DI[7:0];
                end
                2'd2: begin
                    env_mem[mem_A]        <= mem_DI[31:24];
                    env_mem[mem_A + 8'd1] <= mem_DI[23:16];
                    env_mem[mem_A + 8'd2] <= mem_DI[15:8];
                    env_mem[mem_A + 8'd3] <= mem_DI[7:0];
                end
                default: ;
            endcase
        end
    end

    // Reference model state
    logic [7:0]  ref_mem [256];
    int          total = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          acc_cyc = -10;
    int          resp_cyc = -10;
    int          last_port = 1;
    int          g_port = 0;
    logic        g_rw = 1'b0;
    logic [1:0]  g_size = 2'd0;
    logic [7:0]  g_addr = 8'd0;
    logic [31:0] g_wdata = 32'd0;
    logic        g_rej = 1'b0;
    logic [31:0] g_exp = 32'd0;
    logic [31:0] exp_rdata [2];
    logic        pend [2];
    logic        prw [2];
    logic [1:0]  psize [2];
    logic [7:0]  paddr [2];
    logic [31:0] pwdata [2];
    logic        granted [2];
    bit          rand_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic rejected(input logic [1:0] size, input logic [7:0] a);
        logic mis;
        mis = ((size == 2'd1) && a[0]) || ((size == 2'd2) && (a[1:0] != 2'd0));
`ifdef DMEM_ALIGN_CHECK_EN
        return (size == 2'd3) || mis;
`else
        return (size == 2'd3) || (mis && 1'b0);
`endif
    endfunction

    task automatic ref_write(input logic [1:0] size, input logic [7:0] a, input logic [31:0] d);
        case (size)
            2'd0: ref_mem[a] = d[7:0];
            2'd1: begin ref_mem[a] = d[15:8]; ref_mem[a + 8'd1] = d[7:0]; end
            2'd2: begin
                ref_mem[a]        = d[31:24];
                ref_mem[a + 8'd1] = d[23:16];
                ref_mem[a + 8'd2] = d[15:8];
                ref_mem[a + 8'd3] = d[7:0];
            end
            default: ;
        endcase
    endtask

    task automatic drive_ports();
        p0_if.req = pend[0]; p0_if.rw = prw[0]; p0_if.size = psize[0];
        p0_if.addr = paddr[0]; p0_if.wdata = pwdata[0];
        p1_if.req = pend[1]; p1_if.rw = prw[1]; p1_if.size = psize[1];
        p1_if.addr = paddr[1]; p1_if.wdata = pwdata[1];
    endtask

    task automatic set_req(input int p, input logic rw, input logic [1:0] size,
                           input logic [7:0] a, input logic [31:0] d);
        pend[p] = 1'b1; prw[p] = rw; psize[p] = size; paddr[p] = a; pwdata[p] = d;
    endtask

    task automatic new_req(input int p);
        int r;
        r = $urandom_range(0, 9);
        pend[p]   = 1'b1;
        prw[p]    = 1'($urandom_range(0, 1));
        psize[p]  = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
        case ($urandom_range(0, 2))
            0:       paddr[p] = 8'($urandom_range(0, 15));
            1:       paddr[p] = 8'($urandom_range(248, 255));
            default: paddr[p] = 8'($urandom);
        endcase
        pwdata[p] = $urandom;
    endtask

    // One clock: check registered outputs, update requesters, check grants.
    task automatic step();
        int w;
        @(negedge clk);
        cyc++;
        if (cyc == resp_cyc && g_rw && !g_rej) ref_write(g_size, g_addr, g_wdata);

        check("busy",   32'(busy),   32'((cyc == acc_cyc) || (cyc == resp_cyc)));
        check("mem_E",  32'(mem_E),  32'((cyc == acc_cyc) && g_rw && !g_rej));
        check("mem_RW", 32'(mem_RW), 32'((cyc == acc_cyc) && g_rw && !g_rej));
        if (cyc == acc_cyc && !g_rej) begin
            check("mem_A",    32'(mem_A),    32'(g_addr));
            check("mem_Size", 32'(mem_Size), 32'(g_size));
            check("mem_DI",   mem_DI,        g_wdata);
        end
        if (cyc == resp_cyc) begin
            exp_rdata[g_port] = g_exp;
            check("resp_err", 32'(g_port == 1 ? p1_if.err : p0_if.err), 32'(g_rej));
        end
        check("p0_rvalid", 32'(p0_if.rvalid), 32'((cyc == resp_cyc) && (g_port == 0)));
        check("p1_rvalid", 32'(p1_if.rvalid), 32'((cyc == resp_cyc) && (g_port == 1)));
        check("p0_rdata",  p0_if.rdata, exp_rdata[0]);
        check("p1_rdata",  p1_if.rdata, exp_rdata[1]);

        for (int p = 0; p < 2; p++) begin
            if (granted[p] || !pend[p]) begin
                granted[p] = 1'b0;
                if (rand_en && ($urandom_range(0, 99) < 60)) new_req(p);
                else pend[p] = 1'b0;
            end
        end
        drive_ports();
        #1;

        w = -1;
        if (cyc > resp_cyc) begin
            if (pend[0] && pend[1]) w = 1 - last_port;
            else if (pend[0])       w = 0;
            else if (pend[1])       w = 1;
        end
        check("p0_gnt", 32'(p0_if.gnt), 32'(w == 0));
        check("p1_gnt", 32'(p1_if.gnt), 32'(w == 1));
        if (w >= 0) begin
            granted[w] = 1'b1;
            last_port  = w;
            g_port     = w;
            g_rw       = prw[w];
            g_size     = psize[w];
            g_addr     = paddr[w];
            g_wdata    = pwdata[w];
            g_rej      = rejected(psize[w], paddr[w]);
            acc_cyc    = cyc + 1;
            resp_cyc   = cyc + 2;
            g_exp      = (g_rw || g_rej) ? 32'd0 :
                         be_val(g_size, ref_mem[g_addr], ref_mem[g_addr + 8'd1],
                                ref_mem[g_addr + 8'd2], ref_mem[g_addr + 8'd3]);
        end
    endtask

    task automatic run_idle(input int max);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while ((pend[0] || pend[1] || (cyc <= resp_cyc)) && (n < max));
        if (pend[0] || pend[1] || (cyc <= resp_cyc)) check("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic model_reset();
        acc_cyc = -10; resp_cyc = -10; last_port = 1;
        exp_rdata[0] = 32'd0; exp_rdata[1] = 32'd0;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; prw[p] = 1'b0; psize[p] = 2'd0; paddr[p] = 8'd0;
            pwdata[p] = 32'd0; granted[p] = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
        model_reset();
        drive_ports();
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        fill = 1'b0;
        #1;
        check("rst_busy",     32'(busy),          32'd0);
        check("rst_mem_E",    32'(mem_E),         32'd0);
        check("rst_mem_RW",   32'(mem_RW),        32'd0);
        check("rst_mem_A",    32'(mem_A),         32'd0);
        check("rst_mem_DI",   mem_DI,             32'd0);
        check("rst_mem_Size", 32'(mem_Size),      32'd0);
        check("rst_p0_rvld",  32'(p0_if.rvalid),  32'd0);
        check("rst_p1_rvld",  32'(p1_if.rvalid),  32'd0);
        check("rst_p0_err",   32'(p0_if.err),     32'd0);
        check("rst_p1_rdata", p1_if.rdata,        32'd0);
        rst = 1'b0;

        // Contention straight after reset, then again to see alternation.
        set_req(0, 1'b0, 2'd2, 8'h10, 32'd0); set_req(1, 1'b0, 2'd2, 8'h20, 32'd0); run_idle(20);
        set_req(0, 1'b0, 2'd2, 8'h14, 32'd0); set_req(1, 1'b0, 2'd2, 8'h24, 32'd0); run_idle(20);
        set_req(0, 1'b1, 2'd2, 8'h10, 32'hDEADBEEF); run_idle(20);
        set_req(0, 1'b0, 2'd2, 8'h10, 32'd0);        run_idle(20);
        set_req(1, 1'b1, 2'd0, 8'h21, 32'hFFFFFFA5); run_idle(20);
        set_req(1, 1'b0, 2'd1, 8'h20, 32'd0);        run_idle(20);
        set_req(0, 1'b0, 2'd3, 8'h30, 32'd0);        run_idle(20);
        set_req(0, 1'b0, 2'd2, 8'h02, 32'd0);        run_idle(20);
        set_req(0, 1'b1, 2'd2, 8'hFD, 32'h11223344); run_idle(20);
        set_req(1, 1'b0, 2'd2, 8'hFD, 32'd0);        run_idle(20);
        set_req(1, 1'b0, 2'd1, 8'hFF, 32'd0);        run_idle(20);

        rand_en = 1'b1;
        repeat (3000) step();
        rand_en = 1'b0;
        run_idle(50);

        // Reset in the middle of a write access: write must not land, no response.
        set_req(0, 1'b1, 2'd2, 8'h40, 32'hCAFEF00D);
        step();
        step();
        #1 rst = 1'b1;
        #1;
        check("rst_mid_mem_E", 32'(mem_E), 32'd0);
        check("rst_mid_busy",  32'(busy),  32'd0);
        model_reset();
        drive_ports();
        @(negedge clk);
        rst = 1'b0;
        set_req(0, 1'b0, 2'd2, 8'h40, 32'd0); set_req(1, 1'b0, 2'd2, 8'h44, 32'd0); run_idle(20);

        $display("test done: total=%0d bad=%0d", total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
